smart_home_ctrl_p: RTL and testbench
====================================

SMART_HOME_CTRL_P -- requirements
Module: smart_home_ctrl_p

Interface
REQ-001 Parameter: TEMP_W, 7, temperature input width in bits (unsigned).
REQ-002 Parameter: N_WIN, 2, number of window sensor channels (1..8).
REQ-003 Parameter: T_LO, 50, heater turn-on threshold.
REQ-004 Parameter: T_HI, 60, cooler turn-on threshold; T_HI > T_LO + HYST is required.
REQ-005 Parameter: HYST, 2, hysteresis band width.
REQ-006 Parameter: DEB_CYC, 4, consecutive stable samples required by the debounce filter (>=1).
REQ-007 Clk  input  1  single clock; all state updates on rising edge.
REQ-008 Rst  input  1  reset, synchronous, active-high.
REQ-009 SFD  input  1  front-door sensor.
REQ-010 SRD  input  1  rear-door sensor.
REQ-011 SW  input  N_WIN  window sensors, one bit per channel.
REQ-012 SFA  input  1  fire-alarm sensor.
REQ-013 ST  input  TEMP_W  temperature sample.
REQ-014 Ack  input  1  alarm acknowledge.
REQ-015 fdoor, rdoor, winbuzz, alarmbuzz  output  1 each  state-decoded actuators.
REQ-016 heater, cooler  output  1 each  climate actuators.
REQ-017 win_mask  output  N_WIN  debounced window bits, registered.
REQ-018 display  output  3  current state code.

Function
REQ-019 Each of SFD, SRD, SFA and each SW bit SHALL pass an independent debounce filter: filtered value changes only after the raw value differs from it for DEB_CYC consecutive samples; any reversion clears that counter.
REQ-020 FSM states and display codes SHALL be IDLE=0, FDOOR=1, RDOOR=2, WINDOW=3, ALARM=4, CLIMATE=5; codes 6,7 unused and SHALL map to IDLE on the next edge.
REQ-021 Next state SHALL be the highest-priority active filtered request, priority ALARM (SFA) > FDOOR > RDOOR > WINDOW (any win_mask bit) > CLIMATE (heater or cooler set) > IDLE.
REQ-022 Simultaneous requests SHALL resolve by REQ-021 priority; a higher-priority request preempts the current state on the next edge.
REQ-023 Outputs SHALL be Moore decodes of the state register: fdoor=FDOOR, rdoor=RDOOR, winbuzz=WINDOW, alarmbuzz=ALARM; display=state code.
REQ-024 Latency: raw input held steady from cycle 0 SHALL change its filtered value at edge DEB_CYC and the state/outputs at edge DEB_CYC+1.
REQ-025 heater SHALL set when ST < T_LO and clear when ST >= T_LO+HYST; cooler SHALL set when ST > T_HI and clear when ST <= T_HI-HYST; otherwise both hold.
REQ-026 heater and cooler SHALL never be 1 simultaneously and SHALL be forced 0 while state is ALARM.
REQ-027 ST comparisons SHALL be unsigned at TEMP_W bits; ST=0 and ST=2^TEMP_W-1 SHALL behave per REQ-025 without wrap.
REQ-028 win_mask SHALL equal the filtered SW vector, one cycle registered.

Reset
REQ-029 While Rst=1 at a rising edge: state=IDLE, display=0, all actuators=0, win_mask=0, filtered values=0, debounce counters=0.
REQ-030 Reset asserted mid-operation (any state, any counter value) SHALL take effect at that edge; Rst overrides all other inputs including Ack.

Configuration
REQ-031 Macro SMART_HOME_ALARM_LATCH_EN: defined -> once in ALARM, the FSM SHALL stay in ALARM until filtered SFA=0 and Ack=1 on the same edge, then follow REQ-021.
REQ-032 Macro undefined -> ALARM SHALL be left as soon as filtered SFA=0; Ack SHALL be ignored.

Verification
REQ-033 Rst=1 two cycles with all sensors 1 -> display=0, all outputs 0 after reset release edge.
REQ-034 Defaults; SFD=1 for 3 cycles then 0 -> no change; SFD=1 held -> fdoor=1, display=1 at edge 5.
REQ-035 SFD and SFA steady 1 together -> display=4, alarmbuzz=1, fdoor=0, heater=cooler=0.
REQ-036 ST sweep 45,51,52,61,59,58 with no sensors -> heater 1,1,0,0,0,0; cooler 0,0,0,1,1,0; display 5 while either set.
REQ-037 SW=2'b10 held -> win_mask=2'b10, winbuzz=1, display=3; then SW=0 -> display=0 after DEB_CYC+1 edges.
REQ-038 With SMART_HOME_ALARM_LATCH_EN: SFA pulse debounced then cleared -> display stays 4 until Ack=1, then 0; without macro -> display returns 0 without Ack.

Source files
------------

// File: rtl/smart_home_ctrl_p_if.sv
// Sensor/actuator bundle for smart_home_ctrl_p.
// master drives the sensors, slave (the controller) drives the actuators.
interface smart_home_ctrl_p_if #(
  parameter int TEMP_W = 7,
  parameter int N_WIN  = 2
);
  logic              sfd;
  logic              srd;
  logic [N_WIN-1:0]  sw;
  logic              sfa;
  logic [TEMP_W-1:0] st;
  logic              ack;
  logic              fdoor;
  logic              rdoor;
  logic              winbuzz;
  logic              alarmbuzz;
  logic              heater;
  logic              cooler;
  logic [N_WIN-1:0]  win_mask;
  logic [2:0]        display;

  modport master (
    output sfd, srd, sw, sfa, st, ack,
    input  fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, win_mask, display
  );

  modport slave (
    input  sfd, srd, sw, sfa, st, ack,
    output fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, win_mask, display
  );
endinterface

// File: rtl/smart_home_ctrl_p.sv
// Smart-home controller: debounced door/window/fire sensors, priority FSM, hysteretic climate.
// Optional macro SMART_HOME_ALARM_LATCH_EN holds ALARM until fire clears and ack is given.
module smart_home_ctrl_p #(
  parameter int TEMP_W  = 7,
  parameter int N_WIN   = 2,
  parameter int T_LO    = 50,
  parameter int T_HI    = 60,
  parameter int HYST    = 2,
  parameter int DEB_CYC = 4
) (
  input logic               clk,
  input logic               rst,
  smart_home_ctrl_p_if.slave bus
);

  localparam int N_CH  = N_WIN + 3;
  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);
  // Thresholds are one bit wider than ST so T_LO+HYST can never wrap.
  localparam logic [TEMP_W:0] HEAT_ON  = (TEMP_W + 1)'(T_LO);
  localparam logic [TEMP_W:0] HEAT_OFF = (TEMP_W + 1)'(T_LO + HYST);
  localparam logic [TEMP_W:0] COOL_ON  = (TEMP_W + 1)'(T_HI);
  localparam logic [TEMP_W:0] COOL_OFF = (TEMP_W + 1)'(T_HI - HYST);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FDOOR   = 3'd1,
    RDOOR   = 3'd2,
    WINDOW  = 3'd3,
    ALARM   = 3'd4,
    CLIMATE = 3'd5
  } state_t;

  logic [N_CH-1:0]  raw_s;
  logic [N_CH-1:0]  filt_r;
  logic [CNT_W-1:0] cnt_r [N_CH];
  logic [N_WIN-1:0] sw_f_s;
  logic             sfd_f_s, srd_f_s, sfa_f_s;
  state_t           state_r, req_s, state_nxt_s;
  logic [TEMP_W:0]  st_x_s;
  logic             heat_raw_s, cool_raw_s, heat_nxt_s, cool_nxt_s, block_s;
  logic             heater_r, cooler_r;
  logic             fdoor_r, rdoor_r, winbuzz_r, alarmbuzz_r;
  logic [N_WIN-1:0] win_mask_r;
  logic [2:0]       display_r;

  assign raw_s   = {bus.sfa, bus.srd, bus.sfd, bus.sw};
  assign sw_f_s  = filt_r[N_WIN-1:0];
  assign sfd_f_s = filt_r[N_WIN];
  assign srd_f_s = filt_r[N_WIN+1];
  assign sfa_f_s = filt_r[N_WIN+2];

  // Per-channel debounce: flip only after DEB_CYC consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_r <= '0;
      for (int i = 0; i < N_CH; i++) cnt_r[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (raw_s[i] == filt_r[i]) begin
          cnt_r[i] <= '0;
        end else if (cnt_r[i] == CNT_LAST) begin
          filt_r[i] <= raw_s[i];
          cnt_r[i]  <= '0;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end
      end
    end
  end

  // Priority request and next-state selection; unused codes fall back to IDLE.
  always_comb begin
    req_s       = IDLE;
    state_nxt_s = IDLE;
    if (sfa_f_s)                   req_s = ALARM;
    else if (sfd_f_s)              req_s = FDOOR;
    else if (srd_f_s)              req_s = RDOOR;
    else if (|sw_f_s)              req_s = WINDOW;
    else if (heater_r || cooler_r) req_s = CLIMATE;
    else                           req_s = IDLE;
    case (state_r)
      IDLE, FDOOR, RDOOR, WINDOW, CLIMATE: state_nxt_s = req_s;
`ifdef SMART_HOME_ALARM_LATCH_EN
      ALARM: begin
        if (!sfa_f_s && bus.ack) state_nxt_s = req_s;
        else                     state_nxt_s = ALARM;
      end
`else
      ALARM: state_nxt_s = req_s;
`endif
      default: state_nxt_s = IDLE;
    endcase
  end

`ifndef SMART_HOME_ALARM_LATCH_EN
  logic ack_unused_s;
  assign ack_unused_s = bus.ack;
`endif

  // Climate hysteresis; heater wins the (parameter-excluded) overlap, ALARM blocks both.
  always_comb begin
    st_x_s     = {1'b0, bus.st};
    heat_raw_s = heater_r;
    cool_raw_s = cooler_r;
    if (st_x_s < HEAT_ON)        heat_raw_s = 1'b1;
    else if (st_x_s >= HEAT_OFF) heat_raw_s = 1'b0;
    else                         heat_raw_s = heater_r;
    if (st_x_s > COOL_ON)        cool_raw_s = 1'b1;
    else if (st_x_s <= COOL_OFF) cool_raw_s = 1'b0;
    else                         cool_raw_s = cooler_r;
    block_s    = (state_nxt_s == ALARM);
    heat_nxt_s = heat_raw_s & ~block_s;
    cool_nxt_s = cool_raw_s & ~heat_raw_s & ~block_s;
  end

  // State register with outputs decoded from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      fdoor_r     <= 1'b0;
      rdoor_r     <= 1'b0;
      winbuzz_r   <= 1'b0;
      alarmbuzz_r <= 1'b0;
      heater_r    <= 1'b0;
      cooler_r    <= 1'b0;
      win_mask_r  <= '0;
      display_r   <= 3'd0;
    end else begin
      state_r     <= state_nxt_s;
      fdoor_r     <= (state_nxt_s == FDOOR);
      rdoor_r     <= (state_nxt_s == RDOOR);
      winbuzz_r   <= (state_nxt_s == WINDOW);
      alarmbuzz_r <= (state_nxt_s == ALARM);
      heater_r    <= heat_nxt_s;
      cooler_r    <= cool_nxt_s;
      win_mask_r  <= sw_f_s;
      display_r   <= state_nxt_s;
    end
  end

  assign bus.fdoor     = fdoor_r;
  assign bus.rdoor     = rdoor_r;
  assign bus.winbuzz   = winbuzz_r;
  assign bus.alarmbuzz = alarmbuzz_r;
  assign bus.heater    = heater_r;
  assign bus.cooler    = cooler_r;
  assign bus.win_mask  = win_mask_r;
  assign bus.display   = display_r;

endmodule

// File: tb/tb_smart_home_ctrl_p.sv
// Table-driven directed bench for smart_home_ctrl_p (default parameters).
// Expected ALARM release behaviour follows SMART_HOME_ALARM_LATCH_EN when defined.
module tb_smart_home_ctrl_p;
  localparam int TEMP_W = 7;
  localparam int N_WIN  = 2;
`ifdef SMART_HOME_ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  smart_home_ctrl_p_if #(.TEMP_W(TEMP_W), .N_WIN(N_WIN)) bus ();

  smart_home_ctrl_p #(
    .TEMP_W(TEMP_W), .N_WIN(N_WIN), .T_LO(50), .T_HI(60), .HYST(2), .DEB_CYC(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // want = {display, fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler, win_mask}
  typedef struct {
    logic        rst, sfd, srd;
    logic [1:0]  sw;
    logic        sfa;
    logic [6:0]  st;
    logic        ack;
    int          cyc;
    logic [10:0] want;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [10:0] ex(input int d, input bit fd, input bit rd, input bit wb,
                                     input bit ab, input bit ht, input bit cl, input logic [1:0] wm);
    return {3'(d), fd, rd, wb, ab, ht, cl, wm};
  endfunction

  function automatic vec_t mk(input bit r, input bit fd, input bit rd, input logic [1:0] w,
                              input bit fa, input int t, input bit a, input int c,
                              input logic [10:0] want);
    vec_t v;
    v.rst = r; v.sfd = fd; v.srd = rd; v.sw = w; v.sfa = fa;
    v.st = 7'(t); v.ack = a; v.cyc = c; v.want = want;
    return v;
  endfunction

  function automatic logic [10:0] obs();
    return {bus.display, bus.fdoor, bus.rdoor, bus.winbuzz, bus.alarmbuzz,
            bus.heater, bus.cooler, bus.win_mask};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b (disp,fd,rd,wb,ab,ht,cl,wm)", name, got, want);
    end
  endtask

  initial begin
    logic [10:0] zero;
    zero = 11'd0;
    rst = 1'b1;
    bus.sfd = 1'b1; bus.srd = 1'b1; bus.sw = 2'b11; bus.sfa = 1'b1;
    bus.st = 7'd55; bus.ack = 1'b1;

    // reset with everything asserted, release, mid-count reset
    tbl.push_back(mk(1, 1, 1, 2'b11, 1, 55, 1, 2, zero));
    tbl.push_back(mk(0, 1, 1, 2'b11, 1, 55, 0, 1, zero));
    tbl.push_back(mk(1, 1, 1, 2'b11, 1, 55, 1, 1, zero));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 55, 0, 1, zero));
    // short front-door pulse ignored, held one fires at edge 5
    tbl.push_back(mk(0, 1, 0, 2'b00, 0, 55, 0, 3, zero));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 55, 0, 1, zero));
    tbl.push_back(mk(0, 1, 0, 2'b00, 0, 55, 0, 4, zero));
    tbl.push_back(mk(0, 1, 0, 2'b00, 0, 55, 0, 1, ex(1, 1, 0, 0, 0, 0, 0, 2'b00)));
    // fire preempts door; climate blocked in ALARM
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 55, 0, 4, ex(1, 1, 0, 0, 0, 0, 0, 2'b00)));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 55, 0, 1, ex(4, 0, 0, 0, 1, 0, 0, 2'b00)));
    tbl.push_back(mk(0, 1, 0, 2'b00, 1, 45, 0, 2, ex(4, 0, 0, 0, 1, 0, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 55, 0, 4, ex(4, 0, 0, 0, 1, 0, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 55, 0, 1, ex(LATCH ? 4 : 0, 0, 0, 0, LATCH, 0, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 55, 1, 1, zero));
    // rear door over window, then window alone, then window release
    tbl.push_back(mk(0, 0, 1, 2'b10, 0, 55, 0, 5, ex(2, 0, 1, 0, 0, 0, 0, 2'b10)));
    tbl.push_back(mk(0, 0, 0, 2'b10, 0, 55, 0, 5, ex(3, 0, 0, 1, 0, 0, 0, 2'b10)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 55, 0, 4, ex(3, 0, 0, 1, 0, 0, 0, 2'b10)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 55, 0, 1, zero));
    // temperature sweep and boundaries
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 45, 0, 2, ex(5, 0, 0, 0, 0, 1, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 51, 0, 2, ex(5, 0, 0, 0, 0, 1, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 52, 0, 2, zero));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 61, 0, 2, ex(5, 0, 0, 0, 0, 0, 1, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 59, 0, 2, ex(5, 0, 0, 0, 0, 0, 1, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 58, 0, 2, zero));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 50, 0, 2, zero));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 49, 0, 2, ex(5, 0, 0, 0, 0, 1, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 2, ex(5, 0, 0, 0, 0, 1, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 127, 0, 2, ex(5, 0, 0, 0, 0, 0, 1, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 55, 0, 2, zero));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 60, 0, 2, zero));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 61, 0, 1, ex(0, 0, 0, 0, 0, 0, 1, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 61, 0, 1, ex(5, 0, 0, 0, 0, 0, 1, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 55, 0, 2, zero));
    // reset while in FDOOR overrides fire and ack
    tbl.push_back(mk(0, 1, 0, 2'b00, 0, 55, 0, 5, ex(1, 1, 0, 0, 0, 0, 0, 2'b00)));
    tbl.push_back(mk(1, 1, 0, 2'b00, 1, 55, 1, 1, zero));
    tbl.push_back(mk(0, 1, 0, 2'b00, 0, 55, 0, 4, zero));
    tbl.push_back(mk(0, 1, 0, 2'b00, 0, 55, 0, 1, ex(1, 1, 0, 0, 0, 0, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 55, 0, 4, ex(1, 1, 0, 0, 0, 0, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 55, 0, 1, zero));
    // window outranks climate; climate resumes after window clears
    tbl.push_back(mk(0, 0, 0, 2'b01, 0, 45, 0, 5, ex(3, 0, 0, 1, 0, 1, 0, 2'b01)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 45, 0, 5, ex(5, 0, 0, 0, 0, 1, 0, 2'b00)));
    tbl.push_back(mk(0, 0, 0, 2'b00, 0, 55, 0, 2, zero));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; bus.sfd = tbl[i].sfd; bus.srd = tbl[i].srd; bus.sw = tbl[i].sw;
      bus.sfa = tbl[i].sfa; bus.st = tbl[i].st; bus.ack = tbl[i].ack;
      step(tbl[i].cyc);
      check($sformatf("row%0d", i), obs(), tbl[i].want);
    end

    // repeated 3-cycle door glitches never reach the FSM
    for (int r = 0; r < 3; r++) begin
      bus.sfd = 1'b1;
      for (int c = 0; c < 3; c++) begin
        step(1);
        check($sformatf("glitch%0d_%0d", r, c), obs(), zero);
      end
      bus.sfd = 1'b0;
      step(1);
      check($sformatf("glitch%0d_rel", r), obs(), zero);
    end

    // fire latency edge by edge, then release with/without ack
    bus.sfa = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step(1);
      check($sformatf("fire_edge%0d", e), obs(),
            (e == 5) ? ex(4, 0, 0, 0, 1, 0, 0, 2'b00) : zero);
    end
    bus.sfa = 1'b0;
    step(5);
    check("fire_clear", obs(), ex(LATCH ? 4 : 0, 0, 0, 0, LATCH, 0, 0, 2'b00));
    bus.ack = 1'b1;
    step(1);
    check("fire_ack", obs(), zero);
    bus.ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
